// File: rtl/mbist_addr_gen_pkg.sv
// Shared types and default geometry for the MBIST address generator.
package mbist_pkg;

    localparam int DEF_ROW_W = 5;
    localparam int DEF_COL_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        MODE_LINEAR   = 1'b0,
        MODE_ROW_FAST = 1'b1
    } mode_t;

endpackage

// File: rtl/mbist_addr_gen_if.sv
// Control/status bundle between an MBIST controller (master) and the address generator (slave).
interface mbist_addr_gen_if
    import mbist_pkg::*;
#(
    parameter int ADDR_W = DEF_ROW_W + DEF_COL_W
);
    logic              i_start;
    logic              i_abort;
    logic              i_cen;
    logic              i_u_d;
    logic              i_mode;
    logic [ADDR_W-1:0] i_lo_addr;
    logic [ADDR_W-1:0] i_hi_addr;
    logic [ADDR_W-1:0] o_addr;
    logic              o_busy;
    logic              o_last;
    logic              o_done;
    logic              o_err;

    modport master (
        output i_start, i_abort, i_cen, i_u_d, i_mode, i_lo_addr, i_hi_addr,
        input  o_addr, o_busy, o_last, o_done, o_err
    );

    modport slave (
        input  i_start, i_abort, i_cen, i_u_d, i_mode, i_lo_addr, i_hi_addr,
        output o_addr, o_busy, o_last, o_done, o_err
    );

endinterface

// File: rtl/mbist_addr_gen_field_cnt.sv
// Up/down counter for one address field (row or column) with load and enable.
module mbist_field_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic         i_up,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_val,
    output logic         o_carry
);
    logic [W-1:0] r_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_val <= '0;
        end else if (i_load) begin
            r_val <= i_load_val;
        end else if (i_en) begin
            r_val <= i_up ? (r_val + 1'b1) : (r_val - 1'b1);
        end
    end

    // Carry is the raw wrap condition; the parent gates it with its own step so
    // the row/col chaining never forms a combinational loop.
    assign o_carry = i_up ? (&r_val) : (~|r_val);
    assign o_val   = r_val;

endmodule

// File: rtl/mbist_addr_gen.sv
// MBIST address sweep generator: linear (column-fast, bounded) or row-fast (full array) order.
module mbist_addr_gen
    import mbist_pkg::*;
#(
    parameter int ROW_W = DEF_ROW_W,
    parameter int COL_W = DEF_COL_W
) (
    input logic              clk,
    input logic              rst,
    mbist_addr_gen_if.slave  bus
);
    localparam int ADDR_W = ROW_W + COL_W;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_ud;
    mode_t             r_mode;
    logic [ADDR_W-1:0] r_lo;
    logic [ADDR_W-1:0] r_hi;
    logic              r_done;
    logic              r_err;

    logic              w_load;
    logic              w_step;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_last;
    mode_t             w_in_mode;
    logic [ADDR_W-1:0] w_first;
    logic [ADDR_W-1:0] w_term;
    logic [ADDR_W-1:0] w_addr;
    logic [ROW_W-1:0]  w_row;
    logic [COL_W-1:0]  w_col;
    logic              w_row_carry;
    logic              w_col_carry;
    logic              w_row_en;
    logic              w_col_en;

    assign w_in_mode = mode_t'(bus.i_mode);

    assign w_first = (w_in_mode == MODE_LINEAR)
                   ? (bus.i_u_d ? bus.i_lo_addr : bus.i_hi_addr)
                   : (bus.i_u_d ? {ADDR_W{1'b0}} : {ADDR_W{1'b1}});

    assign w_term = (r_mode == MODE_LINEAR)
                  ? (r_ud ? r_hi : r_lo)
                  : (r_ud ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}});

    assign w_addr = {w_row, w_col};
    assign w_last = (r_state == ST_RUN) && (w_addr == w_term);

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    if ((w_in_mode == MODE_LINEAR) && (bus.i_lo_addr > bus.i_hi_addr)) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_next_state = ST_RUN;
                        w_load       = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.i_abort) begin
                    w_next_state = ST_IDLE;
                end else if (bus.i_cen) begin
                    if (w_last) begin
                        w_next_state = ST_IDLE;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Linear order: col is the fast field and carries into row; row-fast swaps the roles.
    assign w_col_en = (r_mode == MODE_ROW_FAST) ? (w_step && w_row_carry) : w_step;
    assign w_row_en = (r_mode == MODE_ROW_FAST) ? w_step : (w_step && w_col_carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ud   <= 1'b1;
            r_mode <= MODE_LINEAR;
            r_lo   <= '0;
            r_hi   <= '0;
        end else if (w_load) begin
            r_ud   <= bus.i_u_d;
            r_mode <= w_in_mode;
            r_lo   <= bus.i_lo_addr;
            r_hi   <= bus.i_hi_addr;
        end
    end

    mbist_field_cnt #(.W(ROW_W)) u_row_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_row_en),
        .i_load     (w_load),
        .i_up       (r_ud),
        .i_load_val (w_first[ADDR_W-1:COL_W]),
        .o_val      (w_row),
        .o_carry    (w_row_carry)
    );

    mbist_field_cnt #(.W(COL_W)) u_col_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_col_en),
        .i_load     (w_load),
        .i_up       (r_ud),
        .i_load_val (w_first[COL_W-1:0]),
        .o_val      (w_col),
        .o_carry    (w_col_carry)
    );

    assign bus.o_addr = w_addr;
    assign bus.o_busy = (r_state == ST_RUN);
    assign bus.o_last = w_last;
    assign bus.o_done = r_done;
    assign bus.o_err  = r_err;

endmodule
